controlador_memoria: RTL and testbench
======================================

CONTROLADOR_MEMORIA -- requirements
Module: controlador_memoria

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning the word-address width; the memory depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the word width.
REQ-003 SHALL have parameter READ_LAT, default 1, meaning the number of wait cycles (0-7) inserted before each read response.
REQ-004 SHALL have port Clock, input, width 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, width 1, the reset; it is synchronous and active-high.
REQ-006 SHALL have port Req, input, width 1, the processor-side transaction request.
REQ-007 SHALL have port Wr, input, width 1: 1 = write, 0 = read; sampled with Req.
REQ-008 SHALL have port Addr, input, width ADDR_W, the processor word address.
REQ-009 SHALL have port WData, input, width DATA_W, the processor write data.
REQ-010 SHALL have port Ack, output, width 1, a one-cycle completion pulse.
REQ-011 SHALL have port RData, output, width DATA_W, the registered read data, valid while Ack=1.
REQ-012 SHALL have port LdValid, input, width 1, the program-loader write strobe.
REQ-013 SHALL have port LdAddr, input, width ADDR_W, the loader word address.
REQ-014 SHALL have port LdData, input, width DATA_W, the loader write data.
REQ-015 SHALL have port LdReady, output, width 1: the loader write is accepted this cycle.
REQ-016 SHALL have port Busy, output, width 1: the FSM is not in IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, READ_WAIT, RESP and WRITE.
REQ-018 SHALL, in IDLE with Req=1, latch Addr, Wr and WData; it then goes to WRITE if Wr=1, else to READ_WAIT if READ_LAT>0, else to RESP.
REQ-019 SHALL stay in READ_WAIT for exactly READ_LAT cycles, using a 3-bit down-counter loaded on acceptance, and then go to RESP.
REQ-020 SHALL, in RESP, drive Ack=1 and RData = mem[latched Addr], with RData captured on the edge entering RESP; the next state is IDLE.
REQ-021 SHALL, in WRITE, drive Ack=1 and commit mem[latched Addr] = latched WData on the edge leaving WRITE; the next state is IDLE.
REQ-022 SHALL produce read latency of READ_LAT+1 cycles from the accepting edge to Ack, and write latency of 1 cycle.
REQ-023 SHALL ignore Addr, Wr and WData changes after acceptance until Ack.
REQ-024 SHALL treat Req still high in the IDLE cycle after Ack as a new request, so back-to-back transactions are legal.
REQ-025 SHALL hold RData stable from a read response until the next read response; writes do not alter RData.
REQ-026 SHALL drive LdReady = (state==IDLE) && !Req, combinationally.
REQ-027 SHALL, when LdValid && LdReady, write mem[LdAddr] = LdData at that edge and keep the FSM in IDLE.
REQ-028 SHALL give Req priority when Req and LdValid are both high in IDLE; the loader must hold LdValid until LdReady.
REQ-029 SHALL return, for a read accepted after a loader write to the same address, the new data.
REQ-030 SHALL let addresses cover the full depth; no out-of-range case exists.

Reset
REQ-031 SHALL, when Reset=1 at an edge, force state IDLE, Ack=0, RData=0, counter=0 and Busy=0.
REQ-032 SHALL NOT clear memory contents on Reset.
REQ-033 SHALL let Reset take priority over every transition; a transaction in progress is aborted with no Ack.
REQ-034 SHALL make no memory write in a cycle where Reset=1, including a WRITE commit and a loader write.

Structure
REQ-035 SHALL place ADDR_W/DATA_W defaults and the 2-bit state encodings (IDLE=0, READ_WAIT=1, RESP=2, WRITE=3) in the shared package memoria_pkg.
REQ-036 SHALL place storage in the sub-module banco_memoria (2**ADDR_W x DATA_W, single synchronous write port muxed between the FSM and the loader, asynchronous read); the FSM, counter and arbitration stay in controlador_memoria.

Verification
REQ-037 SHALL cover the scenario: Reset 2 cycles, then idle -> Ack=0, RData=0x0000, Busy=0, LdReady=1.
REQ-038 SHALL cover the scenario: loader writes 0x1234 to addr 5, then Req read addr 5 (READ_LAT=1) -> Ack exactly 2 cycles after acceptance, RData=0x1234.
REQ-039 SHALL cover the scenario: Req write 0xBEEF to addr 63, Req held high into a read of addr 63 -> Ack at +1 for the write, then Ack for the read returning 0xBEEF.
REQ-040 SHALL cover the scenario: Req and LdValid high together in IDLE (Ld addr 7, data 0x00AA) -> LdReady=0 until the processor Ack, then the loader write completes; read addr 7 = 0x00AA.
REQ-041 SHALL cover the scenario: Req write 0x5555 to addr 3 (prior 0x1111) with Reset asserted in the WRITE cycle -> no Ack, addr 3 still reads 0x1111.
REQ-042 SHALL cover the scenario: READ_LAT=0 build, read addr 0 -> Ack 1 cycle after acceptance, Busy high for exactly 1 cycle.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared types and defaults for the memory controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memoria_pkg;

    localparam int ADDR_W_DEF   = 6;
    localparam int DATA_W_DEF   = 16;
    localparam int READ_LAT_DEF = 1;

    // Controller FSM encoding; the numeric values are visible on debug taps.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RESP      = 2'd2,
        WRITE     = 2'd3
    } state_t;

endpackage

// File: rtl/banco_memoria.sv
// Word storage: 2**ADDR_W x DATA_W, one synchronous write port, asynchronous read.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; the owner arbitrates the single write port.
//
// Ports: core_clk, wr_en/wr_addr/wr_dat (write), rd_addr/rd_dat (read).
module banco_memoria #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              core_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    // No reset on purpose: contents survive a controller reset.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/controlador_memoria.sv
// Processor/loader memory controller: FSM, read wait counter and write-port arbitration.
// Latency: read Ack READ_LAT+1 cycles after acceptance, write Ack 1 cycle after acceptance.
// Backpressure: loader is stalled (LdReady=0) whenever the FSM is busy or Req is high.
//
// Ports: Clock, Reset (sync, active-high); processor side Req/Wr/Addr/WData -> Ack/RData;
//        loader side LdValid/LdAddr/LdData -> LdReady; Busy = FSM not idle.
module controlador_memoria
    import memoria_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    input  logic              LdValid,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdData,
    output logic              LdReady,
    output logic              Busy
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        cnt;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    logic              fsm_we;
    logic              ld_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdat;

    assign LdReady = (state == IDLE) && !Req;
    assign Busy    = (state != IDLE);
    assign Ack     = ack_q;
    assign RData   = rdata_q;

    // The FSM and loader can never write together: the loader only gets the
    // port in IDLE, the FSM only writes from WRITE. Reset blocks both.
    assign fsm_we    = (state == WRITE) && !Reset;
    assign ld_we     = LdValid && LdReady && !Reset;
    assign mem_we    = fsm_we || ld_we;
    assign mem_waddr = fsm_we ? addr_q  : LdAddr;
    assign mem_wdat  = fsm_we ? wdata_q : LdData;

    // With READ_LAT=0 the response is captured on the accepting edge, before
    // addr_q is valid, so the live Addr is used while idle.
    assign mem_raddr = (state == IDLE) ? Addr : addr_q;

    banco_memoria #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_banco (
        .core_clk (Clock),
        .wr_en    (mem_we),
        .wr_addr  (mem_waddr),
        .wr_dat   (mem_wdat),
        .rd_addr  (mem_raddr),
        .rd_dat   (mem_rdat)
    );

    // Wr is only needed at acceptance: it selects WRITE vs the read path, so
    // the chosen state itself is the latched copy.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        addr_q  <= Addr;
                        wdata_q <= WData;
                        if (Wr) begin
                            state <= WRITE;
                            ack_q <= 1'b1;
                        end else if (READ_LAT == 0) begin
                            state   <= RESP;
                            ack_q   <= 1'b1;
                            rdata_q <= mem_rdat;
                        end else begin
                            state <= READ_WAIT;
                            cnt   <= 3'(READ_LAT);
                        end
                    end
                end
                READ_WAIT: begin
                    if (cnt == 3'd1) begin
                        state   <= RESP;
                        ack_q   <= 1'b1;
                        rdata_q <= mem_rdat;
                        cnt     <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_memoria.sv
// Directed bench for controlador_memoria: one READ_LAT=1 instance, one READ_LAT=0 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_controlador_memoria;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;

    // READ_LAT = 1 instance
    logic          req, wr, ack, ld_valid, ld_ready, busy;
    logic [AW-1:0] addr, ld_addr;
    logic [DW-1:0] wdata, rdata, ld_data;

    // READ_LAT = 0 instance
    logic          z_req, z_wr, z_ack, z_ld_valid, z_ld_ready, z_busy;
    logic [AW-1:0] z_addr, z_ld_addr;
    logic [DW-1:0] z_wdata, z_rdata, z_ld_data;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    controlador_memoria #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
        .Clock(clk), .Reset(rst), .Req(req), .Wr(wr), .Addr(addr), .WData(wdata),
        .Ack(ack), .RData(rdata), .LdValid(ld_valid), .LdAddr(ld_addr),
        .LdData(ld_data), .LdReady(ld_ready), .Busy(busy)
    );

    controlador_memoria #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(0)) dut_z (
        .Clock(clk), .Reset(rst), .Req(z_req), .Wr(z_wr), .Addr(z_addr), .WData(z_wdata),
        .Ack(z_ack), .RData(z_rdata), .LdValid(z_ld_valid), .LdAddr(z_ld_addr),
        .LdData(z_ld_data), .LdReady(z_ld_ready), .Busy(z_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loader write on the READ_LAT=1 instance; holds LdValid until accepted.
    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        n = 0;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        ld_valid = 1'b0;
        if (n >= 20) check_val("load_timeout", 32'(n), 32'd0);
    endtask

    // Read on the READ_LAT=1 instance; lat = cycles from accepting edge to Ack.
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        req  = 1'b1;
        wr   = 1'b0;
        addr = a;
        tick();
        req  = 1'b0;
        addr = ~a;
        lat  = 1;
        while (!ack && lat < 20) begin
            tick();
            lat++;
        end
        d = rdata;
    endtask

    logic [DW-1:0] rd;
    int            lat;

    initial begin
        rst = 1'b1;
        req = 0; wr = 0; addr = '0; wdata = '0;
        ld_valid = 0; ld_addr = '0; ld_data = '0;
        z_req = 0; z_wr = 0; z_addr = '0; z_wdata = '0;
        z_ld_valid = 0; z_ld_addr = '0; z_ld_data = '0;

        // Reset for two cycles, then idle outputs
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_ack",     32'(ack),      32'd0);
        check_val("rst_rdata",   32'(rdata),    32'h0000);
        check_val("rst_busy",    32'(busy),     32'd0);
        check_val("rst_ldready", 32'(ld_ready), 32'd1);

        // Loader writes 0x1234 @5, then read @5 with READ_LAT=1
        load(6'd5, 16'h1234);
        req = 1'b1; wr = 1'b0; addr = 6'd5;
        tick();
        req = 1'b0; addr = 6'd9;      // changes after acceptance must be ignored
        check_val("rd5_wait_ack",  32'(ack),  32'd0);
        check_val("rd5_wait_busy", 32'(busy), 32'd1);
        tick();
        check_val("rd5_ack",   32'(ack),   32'd1);
        check_val("rd5_rdata", 32'(rdata), 32'h1234);
        tick();
        check_val("rd5_ack_drop", 32'(ack),   32'd0);
        check_val("rd5_hold",     32'(rdata), 32'h1234);
        check_val("rd5_idle",     32'(busy),  32'd0);

        // Write 0xBEEF @63, Req held high into a read of @63
        req = 1'b1; wr = 1'b1; addr = 6'd63; wdata = 16'hBEEF;
        tick();
        check_val("wr63_ack", 32'(ack), 32'd1);
        wr = 1'b0; wdata = 16'h0000;  // ignored while in WRITE; next request is a read
        tick();
        check_val("wr63_ack_drop", 32'(ack),      32'd0);
        check_val("wr63_ldready",  32'(ld_ready), 32'd0);
        tick();                       // read accepted here
        req = 1'b0;
        check_val("rd63_wait_ack", 32'(ack), 32'd0);
        tick();
        check_val("rd63_ack",   32'(ack),   32'd1);
        check_val("rd63_rdata", 32'(rdata), 32'hBEEF);
        tick();

        // Req and LdValid together: processor wins, loader waits for LdReady
        req = 1'b1; wr = 1'b1; addr = 6'd10; wdata = 16'h0C0C;
        ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 16'h00AA;
        #1;
        check_val("arb_ldready_req", 32'(ld_ready), 32'd0);
        tick();
        req = 1'b0;
        check_val("arb_wr_ack",        32'(ack),      32'd1);
        check_val("arb_ldready_write", 32'(ld_ready), 32'd0);
        tick();
        check_val("arb_ldready_idle", 32'(ld_ready), 32'd1);
        check_val("arb_rdata_kept",   32'(rdata),    32'hBEEF);
        tick();                       // loader write lands on this edge
        ld_valid = 1'b0;
        do_read(6'd7, rd, lat);
        check_val("rd7_lat",   32'(lat), 32'd2);
        check_val("rd7_rdata", 32'(rd),  32'h00AA);
        tick();
        do_read(6'd10, rd, lat);
        check_val("rd10_rdata", 32'(rd), 32'h0C0C);
        tick();

        // Reset during the WRITE cycle aborts the commit
        load(6'd3, 16'h1111);
        req = 1'b1; wr = 1'b1; addr = 6'd3; wdata = 16'h5555;
        tick();
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_ack",   32'(ack),   32'd0);
        check_val("abort_busy",  32'(busy),  32'd0);
        check_val("abort_rdata", 32'(rdata), 32'h0000);
        do_read(6'd3, rd, lat);
        check_val("rd3_lat",   32'(lat), 32'd2);
        check_val("rd3_rdata", 32'(rd),  32'h1111);
        tick();

        // READ_LAT=0 instance: load @0, read @0
        z_ld_valid = 1'b1; z_ld_addr = 6'd0; z_ld_data = 16'hA5A5;
        tick();
        z_ld_valid = 1'b0;
        z_req = 1'b1; z_wr = 1'b0; z_addr = 6'd0;
        #1;
        check_val("z_pre_busy", 32'(z_busy), 32'd0);
        tick();
        z_req = 1'b0; z_addr = 6'd1;
        check_val("z_ack",   32'(z_ack),   32'd1);
        check_val("z_busy",  32'(z_busy),  32'd1);
        check_val("z_rdata", 32'(z_rdata), 32'hA5A5);
        tick();
        check_val("z_ack_drop",  32'(z_ack),   32'd0);
        check_val("z_busy_drop", 32'(z_busy),  32'd0);
        check_val("z_rdata_hold", 32'(z_rdata), 32'hA5A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
